// File: rtl/frequency_meter.sv
// frequency_meter: measures rise-to-rise period and high time of sig_in in clk_in cycles.
// The synchroniser latency is constant, so it cancels out of both measurements.
module frequency_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   s;
  logic                   rise;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             cnt_max;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_d_q;
  assign cnt_max = (cnt_q == CNT_MAX);

  // Synchroniser chain plus one delay flop for edge detection
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d_q  <= s;
    end
  end

  // Period and high-time counters: reload on rise, saturate at all-ones
  always_comb begin
    cnt_d  = cnt_q;
    hcnt_d = hcnt_q;
    if (rise) begin
      cnt_d  = CNT_ONE;
      hcnt_d = CNT_ONE;
    end else begin
      if (!cnt_max) begin
        cnt_d = cnt_q + CNT_ONE;
      end
      if (s && (hcnt_q != CNT_MAX)) begin
        hcnt_d = hcnt_q + CNT_ONE;
      end
    end
  end

  // Measurement FSM: first rise arms, later rises report, saturation without a rise times out
  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        locked_d = 1'b0;
        if (rise) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_d = cnt_q;
          high_d   = hcnt_q;
          valid_d  = 1'b1;
          locked_d = 1'b1;
        end else if (cnt_max) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        locked_d = 1'b0;
      end
    endcase
  end

  // Counter, state and output registers
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      hcnt_q    <= '0;
      state_q   <= IDLE;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      state_q   <= state_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign timeout   = timeout_q;

endmodule
